// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle add/sub/logic/shift,
// radix-2 Booth multiply and non-restoring divide. Define SEQ_ALU_ASR_EN to enable opcode 8 (ASR).
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 div_by_zero,
  output logic                 illegal_op
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_MUL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_DIV_FIX  = CW'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_RSH = 4'd4;
  localparam logic [3:0] OP_LSH = 4'd5;
  localparam logic [3:0] OP_BOR = 4'd6;
  localparam logic [3:0] OP_BAN = 4'd7;
`ifdef SEQ_ALU_ASR_EN
  localparam logic [3:0] OP_ASR = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [3:0]         op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   mq_reg;
  logic               mq_m1_reg;
  logic [WIDTH+1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg, dvs_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               carry_reg, dbz_reg, illegal_reg;

  logic accept;
  logic exec_done;

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign accept      = in_valid && in_ready;
  assign result      = result_reg;
  assign carry       = carry_reg;
  assign div_by_zero = dbz_reg;
  assign illegal_op  = illegal_reg;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    exec_done = 1'b1;
    if (op_reg == OP_MUL)
      exec_done = (cnt_reg == CNT_MUL_LAST);
    else if (op_reg == OP_DIV && b_reg != '0)
      exec_done = (cnt_reg == CNT_DIV_FIX);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = EXEC;
      EXEC:    if (exec_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH-1:0]   bor_w, ban_w;
  logic [2*WIDTH-1:0] single_res;
  logic               single_carry, single_ill;

  assign sh       = b_reg[SW-1:0];
  assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_diff = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bor_w[gi] = a_reg[gi] | b_reg[gi];
      assign ban_w[gi] = a_reg[gi] & b_reg[gi];
    end
  endgenerate

`ifdef SEQ_ALU_ASR_EN
  logic [WIDTH-1:0] asr_w;
  assign asr_w = $signed(a_reg) >>> sh;
`endif

  always_comb begin
    single_res   = '0;
    single_carry = 1'b0;
    single_ill   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        single_res   = {{(WIDTH-1){1'b0}}, add_sum};
        single_carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        single_res   = {{(WIDTH-1){1'b0}}, sub_diff};
        single_carry = sub_diff[WIDTH];
      end
      OP_MUL, OP_DIV: ;
      OP_RSH: single_res = {{WIDTH{1'b0}}, a_reg >> sh};
      OP_LSH: single_res = {{WIDTH{1'b0}}, a_reg << sh};
      OP_BOR: single_res = {{WIDTH{1'b0}}, bor_w};
      OP_BAN: single_res = {{WIDTH{1'b0}}, ban_w};
`ifdef SEQ_ALU_ASR_EN
      OP_ASR: single_res = {{WIDTH{asr_w[WIDTH-1]}}, asr_w};
`endif
      default: single_ill = 1'b1;
    endcase
  end

  // ---------------- Booth multiply step ----------------
  // acc is one bit wider than the operands so that subtracting MIN cannot overflow.
  logic [WIDTH:0]     m_ext, booth_sum;
  logic [2*WIDTH-1:0] mul_prod;

  assign m_ext = {b_reg[WIDTH-1], b_reg};

  always_comb begin
    case ({mq_reg[0], mq_m1_reg})
      2'b01:   booth_sum = acc_reg + m_ext;
      2'b10:   booth_sum = acc_reg - m_ext;
      default: booth_sum = acc_reg;
    endcase
  end

  // Product as it will stand after the shift of the final step.
  assign mul_prod = {booth_sum, mq_reg[WIDTH-1:1]};

  // ---------------- non-restoring divide step ----------------
  // Runs on magnitudes; signs are applied in the final correction clock.
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] rem_sh, rem_step, dvs_ext;
  logic [WIDTH-1:0] quo_step, rem_fix, q_final, r_final;
  logic             q_sign;

  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign dvs_ext  = {2'b00, dvs_reg};
  assign rem_sh   = {rem_reg[WIDTH:0], quo_reg[WIDTH-1]};
  assign rem_step = rem_reg[WIDTH+1] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
  assign quo_step = {quo_reg[WIDTH-2:0], ~rem_step[WIDTH+1]};
  assign rem_fix  = rem_reg[WIDTH-1:0] + (rem_reg[WIDTH+1] ? dvs_reg : '0);
  assign q_sign   = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
  assign q_final  = q_sign ? -quo_reg : quo_reg;
  assign r_final  = a_reg[WIDTH-1] ? -rem_fix : rem_fix;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mq_reg      <= '0;
      mq_m1_reg   <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      result_reg  <= '0;
      carry_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      a_reg       <= a;
      b_reg       <= b;
      op_reg      <= opcode;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mq_reg      <= a;
      mq_m1_reg   <= 1'b0;
      rem_reg     <= '0;
      quo_reg     <= a_mag;
      dvs_reg     <= b_mag;
      dbz_reg     <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (state_reg == EXEC) begin
      cnt_reg <= cnt_reg + CW'(1);
      case (op_reg)
        OP_MUL: begin
          acc_reg   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq_reg    <= {booth_sum[0], mq_reg[WIDTH-1:1]};
          mq_m1_reg <= mq_reg[0];
          if (exec_done) begin
            result_reg <= mul_prod;
            carry_reg  <= 1'b0;
          end
        end
        OP_DIV: begin
          if (b_reg == '0) begin
            result_reg <= {{WIDTH{1'b1}}, a_reg};
            carry_reg  <= 1'b0;
            dbz_reg    <= 1'b1;
          end else if (cnt_reg != CNT_DIV_FIX) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
          end else begin
            result_reg <= {q_final, r_final};
            carry_reg  <= q_sign & (|quo_reg);
          end
        end
        default: begin
          result_reg  <= single_res;
          carry_reg   <= single_carry;
          illegal_reg <= single_ill;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): arithmetic reference model, per-cycle
// output monitor, directed literal cases and randomized traffic with backpressure.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*W-1:0] result;
  logic         carry, div_by_zero, illegal_op;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rand_bp = 1'b0;
  logic force_low = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = force_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: expected outputs and latency from plain arithmetic.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop,
                                output logic [63:0] r, output logic c, output logic dz,
                                output logic il, output int lat);
    longint sa, sb, q, rm;
    logic [63:0] s;
    logic [31:0] t, nb;
    logic [4:0] sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sh = mb[4:0];
    r = '0; c = 1'b0; dz = 1'b0; il = 1'b0; lat = 1;
    case (mop)
      4'd0: begin s = {32'b0, ma} + {32'b0, mb}; r = s; c = s[32]; end
      4'd1: begin nb = ~mb; s = {32'b0, ma} + {32'b0, nb} + 64'd1; r = s; c = s[32]; end
      4'd2: begin r = 64'(sa * sb); lat = 32; end
      4'd3: begin
        if (mb == 32'd0) begin
          r = {32'hFFFF_FFFF, ma}; dz = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb;
          r = {q[31:0], rm[31:0]};
          c = (q[31:0] != 32'd0) && (ma[31] ^ mb[31]);
          lat = 33;
        end
      end
      4'd4: begin t = ma >> sh; r = {32'b0, t}; end
      4'd5: begin t = ma << sh; r = {32'b0, t}; end
      4'd6: r = {32'b0, ma | mb};
      4'd7: r = {32'b0, ma & mb};
`ifdef SEQ_ALU_ASR_EN
      4'd8: begin t = $signed(ma) >>> sh; r = {{32{t[31]}}, t}; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Monitor: every cycle, compare DUT against the model for the transaction in flight.
  logic mon_busy = 1'b0;
  logic mon_seen = 1'b0;
  logic [63:0] m_r;
  logic m_c, m_dz, m_il;
  int m_lat, acc_cyc;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      mon_seen = 1'b0;
    end else if (mon_busy) begin
      chk("in_ready_busy", in_ready, 0);
      if (!out_valid) begin
        chk("not_late", (cyc - acc_cyc) < m_lat, 1);
      end else begin
        if (!mon_seen) begin
          chk("latency", cyc - acc_cyc, m_lat);
          mon_seen = 1'b1;
        end
        chk("result", result, m_r);
        chk("carry", carry, m_c);
        chk("div_by_zero", div_by_zero, m_dz);
        chk("illegal_op", illegal_op, m_il);
        if (out_ready) mon_busy = 1'b0;
      end
    end else begin
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      if (in_valid) begin
        model(a, b, opcode, m_r, m_c, m_dz, m_il, m_lat);
        acc_cyc  = cyc + 1;
        mon_busy = 1'b1;
        mon_seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop, output bit ok);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    a = ia; b = ib; opcode = iop; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    ok = in_ready;
    if (!ok) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] iop, input logic [63:0] er, input logic ec,
                         input logic edz, input logic eil, input int elat, input int hold);
    int n;
    bit ok;
    force_low = (hold > 0);
    issue(ia, ib, iop, ok);
    if (!ok) begin
      force_low = 1'b0;
      return;
    end
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_lat"}, n, elat);
    chk({name, "_res"}, result, er);
    chk({name, "_carry"}, carry, ec);
    chk({name, "_dbz"}, div_by_zero, edz);
    chk({name, "_ill"}, illegal_op, eil);
    $display("op %s a=%h b=%h opcode=%0d -> result=%h carry=%0d latency=%0d", name, ia, ib, iop, result, carry, n);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_res"}, result, er);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_in_ready"}, in_ready, 0);
    end
    force_low = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [63:0] pr;
    logic pc, pdz, pil;
    int plat, k;
    bit ok;
    logic [31:0] ra, rb;
    logic [3:0] rop;

    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_carry", carry, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_ill", illegal_op, 0);
    #10 rst = 1'b0;

    // Pin the model with hand-computed values.
    model(32'hFFFF_FFFF, 32'd1, 4'd0, pr, pc, pdz, pil, plat);
    chk("pin_add_res", pr, 64'h0000_0001_0000_0000);
    chk("pin_add_carry", pc, 1);
    model(32'd5, 32'd7, 4'd1, pr, pc, pdz, pil, plat);
    chk("pin_sub_res", pr, 64'h0000_0000_FFFF_FFFE);
    chk("pin_sub_carry", pc, 0);
    model(32'hFFFF_FFFD, 32'd7, 4'd2, pr, pc, pdz, pil, plat);
    chk("pin_mul_res", pr, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("pin_mul_lat", plat, 32);
    model(32'hFFFF_FFF9, 32'd2, 4'd3, pr, pc, pdz, pil, plat);
    chk("pin_div_res", pr, 64'hFFFF_FFFD_FFFF_FFFF);
    chk("pin_div_carry", pc, 1);
    chk("pin_div_lat", plat, 33);

    // Directed cases with literal expectations.
    run_lit("add_ovf", 32'hFFFF_FFFF, 32'd1, 4'd0, 64'h0000_0001_0000_0000, 1, 0, 0, 1, 0);
    run_lit("sub_borrow", 32'd5, 32'd7, 4'd1, 64'h0000_0000_FFFF_FFFE, 0, 0, 0, 1, 0);
    run_lit("sub_noborrow", 32'd7, 32'd5, 4'd1, 64'h0000_0001_0000_0002, 1, 0, 0, 1, 0);
    run_lit("mul_neg", 32'hFFFF_FFFD, 32'd7, 4'd2, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 0, 32, 0);
    run_lit("div_neg", 32'hFFFF_FFF9, 32'd2, 4'd3, 64'hFFFF_FFFD_FFFF_FFFF, 1, 0, 0, 33, 0);
    run_lit("div_zero", 32'd1234, 32'd0, 4'd3, 64'hFFFF_FFFF_0000_04D2, 0, 1, 0, 1, 0);
    run_lit("div_min", 32'h8000_0000, 32'hFFFF_FFFF, 4'd3, 64'h8000_0000_0000_0000, 0, 0, 0, 33, 0);
    run_lit("lsh", 32'h0000_00F1, 32'd36, 4'd5, 64'h0000_0000_0000_0F10, 0, 0, 0, 1, 0);
`ifdef SEQ_ALU_ASR_EN
    run_lit("op8_asr", 32'h8000_0000, 32'd4, 4'd8, 64'hFFFF_FFFF_F800_0000, 0, 0, 0, 1, 0);
`else
    run_lit("op8_illegal", 32'h8000_0000, 32'd4, 4'd8, 64'h0, 0, 0, 1, 1, 0);
`endif
    run_lit("op15_illegal", 32'h1234_5678, 32'd9, 4'd15, 64'h0, 0, 0, 1, 1, 0);
    run_lit("mul_bp", 32'hFFFF_FFFD, 32'd7, 4'd2, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 0, 32, 5);

    // Randomized traffic with random backpressure; the monitor does the checking.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = rnd_val();
      rb = rnd_val();
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      issue(ra, rb, rop, ok);
      $display("rand %0d a=%h b=%h opcode=%0d", i, ra, rb, rop);
    end
    k = 0;
    while (mon_busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain", mon_busy, 0);
    rand_bp = 1'b0;

    // Reset in the middle of a divide aborts it immediately.
    issue(32'd1000, 32'd7, 4'd3, ok);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_result", result, 0);
    $display("reset mid-DIV: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_lit("post_rst_or", 32'hF0F0_0000, 32'h0000_0F0F, 4'd6, 64'h0000_0000_F0F0_0F0F, 0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
